// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, ID width
// and the byte-enable expansion used by every masked register write.
package irq_ctrl_pkg;

    localparam int IRQ_ID_W = 5;

    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_ENABLE  = 3'd1;
    localparam logic [2:0] REG_SET     = 3'd2;
    localparam logic [2:0] REG_CLEAR   = 3'd3;
    localparam logic [2:0] REG_SECURE  = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Data-bus port (req/gnt/rvalid) between a bus master and the interrupt
// controller's register file.
interface irq_ctrl_if #(
    parameter int ADDR_WIDTH = 22
);

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; id is 0 when nothing is requested.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 32
) (
    input  logic [NUM_SRC-1:0]  req,
    output logic [IRQ_ID_W-1:0] id,
    output logic                valid
);

    // Scan downwards so the last hit, the lowest index, is the one kept.
    always_comb begin
        id    = '0;
        valid = |req;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[k]) id = IRQ_ID_W'(k);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the RI5CY irq_i/irq_id_i/irq_sec_i interface:
// rising-edge capture into PENDING, lowest-ID arbitration, bus register file.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int NUM_SRC    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_SRC-1:0]  irq_src_i,
    output logic                irq_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    output logic                irq_sec_o,
    input  logic                irq_ack_i,
    input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
    irq_ctrl_if.slave           bus
);

    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  enable;
    logic [NUM_SRC-1:0]  secure;
    logic [NUM_SRC-1:0]  prev;
    logic                primed;

    logic [NUM_SRC-1:0]  active;
    logic [NUM_SRC-1:0]  edge_det;
    logic [NUM_SRC-1:0]  set_v;
    logic [NUM_SRC-1:0]  clr_v;
    logic [NUM_SRC-1:0]  wr_mask;
    logic [NUM_SRC-1:0]  wdata_m;
    logic [31:0]         byte_m;
    logic [31:0]         sec_w;
    logic [31:0]         rd_val;
    logic [2:0]          sel;
    logic                wr;
    logic [IRQ_ID_W-1:0] enc_id;
    logic                enc_vld;

    logic                vld_p1;
    logic [31:0]         rdata_p1;

    assign sel     = bus.addr[4:2];
    assign wr      = bus.req & bus.we;
    assign byte_m  = be_to_mask(bus.be);
    assign wr_mask = byte_m[NUM_SRC-1:0];
    assign wdata_m = bus.wdata[NUM_SRC-1:0] & wr_mask;

    // Edges are suppressed until prev has been loaded once after reset, so a
    // source already high at release does not look like a fresh edge.
    assign edge_det = primed ? (irq_src_i & ~prev) : '0;
    assign set_v    = edge_det | ((wr && sel == REG_SET) ? wdata_m : '0);

    always_comb begin
        clr_v = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (irq_ack_i && 32'(irq_ack_id_i) == k) clr_v[k] = 1'b1;
        end
        if (wr && sel == REG_CLEAR) clr_v = clr_v | wdata_m;
    end

    assign active = pending & enable;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (active),
        .id    (enc_id),
        .valid (enc_vld)
    );

    assign irq_o     = enc_vld;
    assign irq_id_o  = enc_id;
    assign sec_w     = 32'(secure);
    assign irq_sec_o = sec_w[enc_id] & enc_vld;

    always_comb begin
        rd_val = '0;
        if (!bus.we) begin
            case (sel)
                REG_PENDING: rd_val = 32'(pending);
                REG_ENABLE:  rd_val = 32'(enable);
                REG_SECURE:  rd_val = 32'(secure);
                REG_STATUS:  rd_val = {irq_o, 26'b0, irq_id_o};
                default:     rd_val = '0;
            endcase
        end
    end

    // p0 -> p1: state update and bus response register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending  <= '0;
            enable   <= '0;
            secure   <= '0;
            prev     <= '0;
            primed   <= 1'b0;
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            prev     <= irq_src_i;
            primed   <= 1'b1;
            pending  <= (pending & ~clr_v) | set_v;
            if (wr && sel == REG_ENABLE) enable <= (enable & ~wr_mask) | wdata_m;
            if (wr && sel == REG_SECURE) secure <= (secure & ~wr_mask) | wdata_m;
            vld_p1   <= bus.req;
            rdata_p1 <= bus.req ? rd_val : '0;
        end
    end

    assign bus.gnt    = bus.req;
    assign bus.rvalid = vld_p1;
    assign bus.rdata  = rdata_p1;

endmodule
